instr_prefetch: RTL and testbench

Upstream fetch front-end of the 5-stage pipeline. It drives the synchronous instruction ROM (1-cycle read latency) and buffers returned instructions in a small FIFO. It presents a registered IF/ID instruction to decode, holding it on HDU stall without refetching. A redirect port flushes all fetched state, ready for future jump/branch support.

---
 rtl/instr_prefetch.sv | 112 +++++++++++
 tb/tb_instr_prefetch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch: drives a 1-cycle sync ROM, buffers returns in a credit-limited FIFO, feeds registered IF/ID.
// Fetch-to-decode latency 2 edges; stall holds IF/ID and lets the FIFO fill until credits run out; redirect flushes all.
module instr_prefetch #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 8,
  parameter int DEPTH = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 8'h00
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    stall,
  input  logic                    fetch_en,
  input  logic                    redirect_en,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [INSTR_W-1:0]      rom_q,
  output logic [INSTR_W-1:0]      if_id_reg,
  output logic [ADDR_W-1:0]       if_id_pc,
  output logic                    if_id_valid,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;

  logic [INSTR_W-1:0] buf_instr [DEPTH];
  logic [ADDR_W-1:0]  buf_pc    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  logic [CNT_W-1:0]   occupancy;
  logic               fifo_empty;
  logic               issue;
  logic               push;
  logic               pop;

  assign rom_addr   = pc;
  assign fifo_count = cnt;
  assign fifo_empty = (cnt == '0);

  // The outstanding read holds a FIFO slot so its return can always be absorbed.
  assign occupancy = cnt + CNT_W'(inflight);
  assign issue     = fetch_en && !redirect_en && (occupancy < CNT_W'(DEPTH));

  // A return is buffered unless it can go straight into IF/ID this edge.
  assign push = inflight && !redirect_en && (stall || !fifo_empty);
  assign pop  = !redirect_en && !stall && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= rom_q;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      if_id_reg   <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (redirect_en) begin
      pc          <= redirect_pc;
      inflight    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      if_id_reg   <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight    <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);

      if (!stall) begin
        if (pop) begin
          if_id_reg   <= buf_instr[rd_ptr];
          if_id_pc    <= buf_pc[rd_ptr];
          if_id_valid <= 1'b1;
        end else if (inflight) begin
          if_id_reg   <= rom_q;
          if_id_pc    <= inflight_pc;
          if_id_valid <= 1'b1;
        end else begin
          if_id_reg   <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: ROM model mem[i] = 8'h10 + i (low byte), hand-computed expectations.
module tb_instr_prefetch;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        fetch_en;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic [15:0] rom_addr;
  logic [7:0]  rom_q;
  logic [7:0]  if_id_reg;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  instr_prefetch dut (
    .clk         (clk),
    .resetn      (resetn),
    .stall       (stall),
    .fetch_en    (fetch_en),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .if_id_reg   (if_id_reg),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) rom_q <= 8'h10 + rom_addr[7:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] r, input logic [15:0] p, input logic v);
    check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
    check({tag, ".reg"}, {24'b0, if_id_reg}, {24'b0, r});
    if (v) check({tag, ".pc"}, {16'b0, if_id_pc}, {16'b0, p});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after an edge with reset released and fetching.
  task automatic restart;
    resetn = 1'b0; fetch_en = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    step();
    step();
    resetn = 1'b1; fetch_en = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; stall = 1'b0; fetch_en = 1'b0;
    redirect_en = 1'b0; redirect_pc = 16'h0;
    step();
    step();
    // Reset state
    check_out("rst", 8'h00, 16'h0, 1'b0);
    check("rst.pc_out", {16'b0, if_id_pc}, 32'h0);
    check("rst.count", {29'b0, fifo_count}, 32'h0);
    check("rst.rom_addr", {16'b0, rom_addr}, 32'h0);

    // Streaming from reset release
    resetn = 1'b1; fetch_en = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (e == 1) check_out("stream.e1", 8'h00, 16'h0, 1'b0);
      else        check_out("stream", 8'h10 + 8'(e - 2), 16'(e - 2), 1'b1);
      check("stream.count", {29'b0, fifo_count}, 32'h0);
    end

    // Stall for 6 edges after 8'h11 is loaded
    restart();
    step(); step(); step();
    check_out("pre_stall", 8'h11, 16'h1, 1'b1);
    stall = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step();
      check_out("stall.hold", 8'h11, 16'h1, 1'b1);
      check("stall.count", {29'b0, fifo_count}, (e < 4) ? 32'(e + 1) : 32'd4);
      check("stall.rom_addr", {16'b0, rom_addr}, (e < 3) ? 32'(e + 4) : 32'd6);
    end
    stall = 1'b0;
    for (int e = 0; e < 5; e++) begin
      step();
      check_out("stall.release", 8'h12 + 8'(e), 16'(e + 2), 1'b1);
    end

    // Redirect while FIFO holds 3 under stall
    restart();
    step(); step(); step();
    stall = 1'b1;
    step(); step(); step();
    check("redir.count_before", {29'b0, fifo_count}, 32'd3);
    redirect_en = 1'b1; redirect_pc = 16'h0040;
    step();
    check_out("redir.flush", 8'h00, 16'h0, 1'b0);
    check("redir.count", {29'b0, fifo_count}, 32'd0);
    check("redir.pc", {16'b0, rom_addr}, 32'h40);
    redirect_en = 1'b0; stall = 1'b0;
    step();
    check_out("redir.bubble", 8'h00, 16'h0, 1'b0);
    step();
    check_out("redir.first", 8'h50, 16'h0040, 1'b1);
    step();
    check_out("redir.second", 8'h51, 16'h0041, 1'b1);

    // PC wrap via redirect to FFFE
    redirect_en = 1'b1; redirect_pc = 16'hFFFE;
    step();
    check_out("wrap.flush", 8'h00, 16'h0, 1'b0);
    redirect_en = 1'b0;
    step();
    check_out("wrap.bubble", 8'h00, 16'h0, 1'b0);
    step(); check_out("wrap.fffe", 8'h0E, 16'hFFFE, 1'b1);
    step(); check_out("wrap.ffff", 8'h0F, 16'hFFFF, 1'b1);
    step(); check_out("wrap.0000", 8'h10, 16'h0000, 1'b1);
    step(); check_out("wrap.0001", 8'h11, 16'h0001, 1'b1);

    // fetch_en dropped with 2 buffered plus one in flight
    restart();
    step(); step(); step();
    stall = 1'b1;
    step(); step();
    check("drain.count_before", {29'b0, fifo_count}, 32'd2);
    stall = 1'b0; fetch_en = 1'b0;
    step(); check_out("drain.0", 8'h12, 16'h2, 1'b1);
    check("drain.count0", {29'b0, fifo_count}, 32'd2);
    step(); check_out("drain.1", 8'h13, 16'h3, 1'b1);
    step(); check_out("drain.2", 8'h14, 16'h4, 1'b1);
    check("drain.count2", {29'b0, fifo_count}, 32'd0);
    for (int e = 0; e < 4; e++) begin
      step();
      check_out("drain.bubble", 8'h00, 16'h0, 1'b0);
    end

    // Reset pulse with a read in flight
    restart();
    step(); step(); step(); step();
    check_out("mid.pre", 8'h12, 16'h2, 1'b1);
    resetn = 1'b0;
    #1;
    check_out("mid.async", 8'h00, 16'h0, 1'b0);
    check("mid.async_pc", {16'b0, if_id_pc}, 32'h0);
    check("mid.async_count", {29'b0, fifo_count}, 32'h0);
    check("mid.async_addr", {16'b0, rom_addr}, 32'h0);
    #1;
    resetn = 1'b1;
    step(); check_out("mid.e1", 8'h00, 16'h0, 1'b0);
    step(); check_out("mid.e2", 8'h10, 16'h0, 1'b1);
    step(); check_out("mid.e3", 8'h11, 16'h1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
